// File: rtl/mvmult_row_sequencer.sv
// rtl/mvmult_row_sequencer.sv - one-row dot-product sequencer over ROM/vector memories
// Define MVSEQ_SAT_EN to clamp the rescaled result instead of wrapping it.
module mvmult_row_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int N_COLS = 8,
  parameter int FRAC_W = 12,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address0,
  output logic              rom_ce0,
  input  logic [DATA_W-1:0] rom_q0,
  output logic [ADDR_W-1:0] vec_address0,
  output logic              vec_ce0,
  input  logic [DATA_W-1:0] vec_q0,
  output logic [DATA_W-1:0] y_out,
  output logic              y_valid,
  input  logic              y_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(N_COLS - 1);

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        y_q, y_d;
  logic                     done_q, done_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    sum;
  logic [DATA_W-1:0]          y_next;

  // Operands are sign-extended to the product width so the low 2*DATA_W bits are exact.
  assign prod = $signed({{DATA_W{rom_q0[DATA_W-1]}}, rom_q0}) *
                $signed({{DATA_W{vec_q0[DATA_W-1]}}, vec_q0});
  assign sum  = acc_q + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});

`ifdef MVSEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  assign shifted = sum >>> FRAC_W;

  always_comb begin
    if (shifted > Y_MAX)      y_next = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < Y_MIN) y_next = {1'b1, {(DATA_W-1){1'b0}}};
    else                      y_next = shifted[DATA_W-1:0];
  end
`else
  assign y_next = sum[FRAC_W +: DATA_W];
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    y_d     = y_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Read data lags the address by one cycle, so the first RUN cycle has nothing to add.
        if (k_q != '0) acc_d = sum;
        if (k_q == K_LAST) state_d = S_DRAIN;
        else               k_d     = k_q + ADDR_W'(1);
      end
      S_DRAIN: begin
        acc_d   = sum;
        y_d     = y_next;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (y_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign rom_ce0      = (state_q == S_RUN);
  assign vec_ce0      = rom_ce0;
  assign rom_address0 = k_q;
  assign vec_address0 = k_q;
  assign y_out        = y_q;
  assign y_valid      = (state_q == S_OUT);

endmodule

// File: tb/tb_mvmult_row_sequencer.sv
// tb/tb_mvmult_row_sequencer.sv - randomized self-checking bench for mvmult_row_sequencer
// Honours MVSEQ_SAT_EN in its reference model exactly as the design does.
module tb_mvmult_row_sequencer;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          y_ready = 1'b0;
  logic          busy, done, rom_ce0, vec_ce0, y_valid;
  logic [AW-1:0] rom_address0, vec_address0;
  logic [DW-1:0] rom_q0 = '0;
  logic [DW-1:0] vec_q0 = '0;
  logic [DW-1:0] y_out;

  logic [DW-1:0] rom_m [N];
  logic [DW-1:0] vec_m [N];

  int nvec = 0;
  int nerr = 0;
  int ce_cnt = 0;
  int prot_err = 0;

  mvmult_row_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rom_address0(rom_address0), .rom_ce0(rom_ce0), .rom_q0(rom_q0),
    .vec_address0(vec_address0), .vec_ce0(vec_ce0), .vec_q0(vec_q0),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_ce0) rom_q0 <= rom_m[rom_address0];
    if (vec_ce0) vec_q0 <= vec_m[vec_address0];
  end

  always @(negedge clk) begin
    if (rom_ce0 === 1'b1) ce_cnt++;
    if (rom_ce0 !== vec_ce0 || rom_address0 !== vec_address0 || (rom_ce0 === 1'b1 && busy !== 1'b1))
      prot_err++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [DW-1:0] ref_y();
    longint s = 0;
    for (int k = 0; k < N; k++)
      s += longint'($signed(rom_m[k])) * longint'($signed(vec_m[k]));
    s = s >>> 12;
`ifdef MVSEQ_SAT_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [11:0] r;
    logic [31:0] w;
    w = $urandom;
    r = w[11:0];
    if ($urandom_range(0, 3) == 0) return w[DW-1:0];
    return {{4{r[11]}}, r};
  endfunction

  task automatic run_row(input bit pre, input bit chain, input int bp, input bit poke,
                         output int lat, output logic [DW-1:0] y, output bit stable,
                         output bit done_ok, output int ces);
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
    end
    ce_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (y_valid !== 1'b1 && lat < 40) begin
      start = poke & lat[0];
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    y = y_out;
    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      start = poke;
      @(negedge clk);
      if (y_valid !== 1'b1 || y_out !== y) stable = 1'b0;
    end
    start = 1'b0;
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    done_ok = (done === 1'b1) && (y_valid === 1'b0) && (busy === 1'b0);
    ces = ce_cnt;
    if (chain) start = 1'b1;
    else begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
    nvec++; if (rom_ce0 !== 1'b0 || vec_ce0 !== 1'b0) begin nerr++; $display("FAIL reset_ce got %b%b want 00", rom_ce0, vec_ce0); end
    nvec++; if (rom_address0 !== '0 || vec_address0 !== '0) begin nerr++; $display("FAIL reset_addr got %0d/%0d want 0", rom_address0, vec_address0); end
    nvec++; if (y_valid !== 1'b0) begin nerr++; $display("FAIL reset_y_valid got %b want 0", y_valid); end
    nvec++; if (y_out !== '0) begin nerr++; $display("FAIL reset_y_out got %h want 0000", y_out); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_one_hot();
    int lat, ces; logic [DW-1:0] y; bit st, dok;
    rom_m = '{16'h8FBE, 16'h03E4, 16'h50B5, 16'h0613, 16'h2D51, 16'h074D, 16'h1972, 16'h07FD};
    vec_m = '{default: 16'h0000};
    vec_m[3] = 16'h1000;
    run_row(0, 0, 0, 0, lat, y, st, dok, ces);
    nvec++; if (lat != 10) begin nerr++; $display("FAIL one_hot_latency got %0d want 10", lat); end
    nvec++; if (y !== 16'h0613) begin nerr++; $display("FAIL one_hot_y got %h want 0613", y); end
    nvec++; if (!dok) begin nerr++; $display("FAIL one_hot_done got 0 want 1-cycle pulse"); end
    nvec++; if (ces != N) begin nerr++; $display("FAIL one_hot_ce_cycles got %0d want %0d", ces, N); end
  endtask

  task automatic test_signed();
    int lat, ces; logic [DW-1:0] y; bit st, dok;
    vec_m = '{default: 16'h0000};
    vec_m[0] = 16'h1000;
    run_row(0, 0, 0, 0, lat, y, st, dok, ces);
    nvec++; if (y !== 16'h8FBE) begin nerr++; $display("FAIL signed_y got %h want 8FBE", y); end
  endtask

  task automatic test_overflow();
    int lat, ces; logic [DW-1:0] y; bit st, dok;
    logic [DW-1:0] want;
`ifdef MVSEQ_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'h8000;
`endif
    rom_m = '{default: 16'h1000};
    vec_m = '{default: 16'h1000};
    run_row(0, 0, 0, 0, lat, y, st, dok, ces);
    nvec++; if (y !== want) begin nerr++; $display("FAIL overflow_y got %h want %h", y, want); end
  endtask

  task automatic test_random();
    int lat, ces; logic [DW-1:0] y, want; bit st, dok;
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < N; k++) begin
        rom_m[k] = rnd_word();
        vec_m[k] = rnd_word();
      end
      want = ref_y();
      run_row(0, 0, $urandom_range(0, 3), 0, lat, y, st, dok, ces);
      nvec++; if (y !== want) begin nerr++; $display("FAIL random_y row %0d got %h want %h", r, y, want); end
      nvec++; if (lat != 10 || !dok || !st) begin nerr++; $display("FAIL random_handshake row %0d lat %0d done %b stable %b want 10/1/1", r, lat, dok, st); end
    end
  endtask

  task automatic test_backpressure();
    int lat, ces; logic [DW-1:0] y, want; bit st, dok;
    for (int k = 0; k < N; k++) begin
      rom_m[k] = rnd_word();
      vec_m[k] = rnd_word();
    end
    want = ref_y();
    run_row(0, 0, 5, 1, lat, y, st, dok, ces);
    nvec++; if (st !== 1'b1) begin nerr++; $display("FAIL bp_stable got 0 want 1"); end
    nvec++; if (y !== want) begin nerr++; $display("FAIL bp_y got %h want %h", y, want); end
    nvec++; if (lat != 10) begin nerr++; $display("FAIL bp_latency got %0d want 10", lat); end
    nvec++; if (!dok) begin nerr++; $display("FAIL bp_done got 0 want 1-cycle pulse then idle"); end
    nvec++; if (ces != N) begin nerr++; $display("FAIL bp_ce_cycles got %0d want %0d", ces, N); end
  endtask

  task automatic test_reset_mid_run();
    int lat, ces; logic [DW-1:0] y, want; bit st, dok;
    rom_m = '{default: 16'h7FFF};
    vec_m = '{default: 16'h7FFF};
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nvec++; if (busy !== 1'b0 || rom_ce0 !== 1'b0 || vec_ce0 !== 1'b0 || y_valid !== 1'b0)
      begin nerr++; $display("FAIL midrst_state got busy %b ce %b%b valid %b want 0", busy, rom_ce0, vec_ce0, y_valid); end
    for (int k = 0; k < N; k++) begin
      rom_m[k] = rnd_word();
      vec_m[k] = rnd_word();
    end
    want = ref_y();
    run_row(0, 0, 0, 0, lat, y, st, dok, ces);
    nvec++; if (y !== want || lat != 10) begin nerr++; $display("FAIL midrst_y got %h lat %0d want %h lat 10", y, lat, want); end
  endtask

  task automatic test_back_to_back();
    int lat_a, lat_b, ces_a, ces_b; logic [DW-1:0] ya, yb, wa, wb; bit st, dok_a, dok_b;
    logic [DW-1:0] rb [N];
    logic [DW-1:0] vb [N];
    for (int k = 0; k < N; k++) begin
      rom_m[k] = rnd_word();
      vec_m[k] = rnd_word();
      rb[k] = rnd_word();
      vb[k] = rnd_word();
    end
    wa = ref_y();
    run_row(0, 1, 1, 0, lat_a, ya, st, dok_a, ces_a);
    rom_m = rb;
    vec_m = vb;
    wb = ref_y();
    run_row(1, 0, 0, 0, lat_b, yb, st, dok_b, ces_b);
    nvec++; if (ya !== wa) begin nerr++; $display("FAIL b2b_y_first got %h want %h", ya, wa); end
    nvec++; if (yb !== wb) begin nerr++; $display("FAIL b2b_y_second got %h want %h", yb, wb); end
    nvec++; if (lat_b != 10) begin nerr++; $display("FAIL b2b_latency got %0d want 10", lat_b); end
    nvec++; if (ces_a != N || ces_b != N) begin nerr++; $display("FAIL b2b_ce_cycles got %0d/%0d want %0d", ces_a, ces_b, N); end
    nvec++; if (!dok_a || !dok_b) begin nerr++; $display("FAIL b2b_done got %b/%b want 1/1", dok_a, dok_b); end
  endtask

  task automatic test_protocol();
    nvec++; if (prot_err != 0) begin nerr++; $display("FAIL mem_protocol got %0d violations want 0", prot_err); end
  endtask

  initial begin
    rom_m = '{default: 16'h0000};
    vec_m = '{default: 16'h0000};
    test_reset();
    test_one_hot();
    test_signed();
    test_overflow();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mvmult_row_sequencer.md
Name: mvmult_row_sequencer

Overview:
- Sequences one dense constraint row dot product, y = sum over k of D[k]·x[k], for the MPC controller.
- Drives a 1-read-port synchronous ROM holding row coefficients D and a 1-read-port synchronous vector memory holding x.
- Multiply-accumulates signed fixed-point products, rescales, optionally saturates.
- Presents y to the downstream constraint-check stage over a valid/ready handshake.

Parameters:
- DATA_W, 16: width of D, x and y; signed two's complement.
- ADDR_W, 3: address width of ROM and vector memory.
- N_COLS, 8: number of row elements; 1 ≤ N_COLS ≤ 2^ADDR_W.
- FRAC_W, 12: fractional bits of D, x and y; product is shifted right by FRAC_W.
- ACC_W, 40: accumulator width; ≥ 2·DATA_W + ceil(log2(N_COLS)).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request one row computation; sampled only in IDLE
- busy  out  1  high in RUN, DRAIN and OUT states
- done  out  1  one-cycle pulse when the y handshake completes
- rom_address0  out  ADDR_W  coefficient ROM address
- rom_ce0  out  1  coefficient ROM read enable
- rom_q0  in  DATA_W  ROM data, valid one cycle after ce
- vec_address0  out  ADDR_W  vector memory address, always equal to rom_address0
- vec_ce0  out  1  vector memory read enable, always equal to rom_ce0
- vec_q0  in  DATA_W  vector data, valid one cycle after ce
- y_out  out  DATA_W  rescaled dot product
- y_valid  out  1  y_out valid
- y_ready  in  1  downstream accepts y_out

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - State IDLE; counter 0; accumulator 0.
  - busy=0, done=0, rom_ce0=vec_ce0=0, addresses 0, y_valid=0, y_out=0.
  - Any in-flight read data is discarded.
- States: IDLE → RUN → DRAIN → OUT → IDLE.
- IDLE:
  - start=1 at edge T: accumulator cleared, counter k=0, go to RUN.
  - start=0: remain in IDLE.
- RUN (cycles T+1 .. T+N_COLS):
  - Assert ce0 on both memories with address k; increment k each cycle.
  - Each cycle after the first, add the product of the previous cycle's rom_q0·vec_q0 (full 2·DATA_W signed) into the accumulator.
  - After address N_COLS-1 has been issued, go to DRAIN.
- DRAIN (cycle T+N_COLS+1):
  - ce0=0.
  - Accumulate the final product.
  - Compute y = acc >>> FRAC_W (arithmetic shift, truncation toward −inf) and reduce it to DATA_W (see Optional Feature).
  - Register y into y_out; go to OUT.
- OUT:
  - y_valid=1 from cycle T+N_COLS+2; for N_COLS=8 that is 10 cycles after start is sampled.
  - y_out stays stable while y_valid=1 and y_ready=0.
  - On a cycle with y_valid=1 and y_ready=1:
    - y_valid drops the next cycle.
    - done pulses high for exactly one cycle, the cycle after the handshake.
    - State returns to IDLE.
- start while busy: ignored, no queuing.
- start asserted in the same cycle done pulses: accepted, since the state is already IDLE; the new RUN begins next cycle.
- Memory pins: ce0 never asserted outside RUN. Addresses hold their last value when ce0=0.
- Accumulator: never wraps for legal parameters; overflow handling applies only at the output reduction.

Optional Feature:
- Macro MVSEQ_SAT_EN.
- Defined: the shifted result is clamped to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; for DATA_W=16 that is 0x8000..0x7FFF.
- Undefined: the shifted result is truncated to its low DATA_W bits (two's-complement wrap). No other behaviour differs.

Test Plan:
- One-hot accumulation: ROM = {0x8FBE, 0x03E4, 0x50B5, 0x0613, 0x2D51, 0x074D, 0x1972, 0x07FD}, x[3]=0x1000, all other x=0, start pulse → y_valid at T+10, y_out=0x0613, y_ready=1 → done pulse next cycle.
- Signed path: x[0]=0x1000, all other x=0 → y_out=0x8FBE (negative coefficient passes unchanged).
- Overflow: all D=0x1000, all x=0x1000 (true result 8.0):
  - With MVSEQ_SAT_EN → y_out=0x7FFF.
  - Without MVSEQ_SAT_EN → y_out=0x8000.
- Backpressure: y_ready held 0 for 5 cycles after y_valid → y_out and y_valid stable; start pulses during busy ignored; done follows the first ready cycle.
- Reset mid-RUN (cycle T+4):
  - Next cycle: busy=0, ce0=0, y_valid=0.
  - A new start yields a correct result uncorrupted by the partial accumulation.
- Back-to-back: start asserted in the done cycle → second RUN begins the next cycle; ce0 is asserted exactly 8 cycles per row.
